// File: rtl/muldiv_unit.sv
// muldiv_unit: RV32M multiply (fixed latency) and restoring divide/remainder for the EX stage.
// done is the FIN state itself; result/rd_out load on the edge into FIN.
module muldiv_unit #(
    parameter int XLEN = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);
    localparam int CW = $clog2(XLEN + 1);
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [2:0] f3, mf3;
    logic [XLEN-1:0] a, b, rem, quo, dv, ma, mb, mul_res, spec_res, rem_n, quo_n, div_res, load_val;
    logic [4:0] rd;
    logic neg_q, neg_r, accept, dz, ovf, ge, load, sgn;
    logic [2*XLEN+1:0] prod;
    logic [XLEN:0] rs, sub;
    assign accept = state == IDLE && start && !flush;
    assign busy = state != IDLE;
    assign done = state == FIN;
    // Single-cycle multiply must be computed straight from the inputs at accept
    assign mf3 = state == IDLE ? funct3 : f3;
    assign ma = state == IDLE ? op_a : a;
    assign mb = state == IDLE ? op_b : b;
    assign prod = {{(XLEN+2){mf3[1:0] != 2'b11 && ma[XLEN-1]}}, ma} * {{(XLEN+2){!mf3[1] && mb[XLEN-1]}}, mb};
    assign mul_res = mf3[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    assign dz = op_b == '0;
    assign ovf = !funct3[0] && op_a == {1'b1, {(XLEN-1){1'b0}}} && op_b == '1;
    assign spec_res = dz ? (funct3[1] ? op_a : '1) : (funct3[1] ? '0 : op_a);
    assign rs = {rem, quo[XLEN-1]};
    assign sub = rs - {1'b0, dv};
    assign ge = !sub[XLEN];
    assign rem_n = ge ? sub[XLEN-1:0] : rs[XLEN-1:0];
    assign quo_n = {quo[XLEN-2:0], ge};
    assign div_res = f3[1] ? (neg_r ? -rem_n : rem_n) : (neg_q ? -quo_n : quo_n);
    assign sgn = !f3[0];
    always_comb begin
        state_n = state;
        load = 1'b0;
        load_val = mul_res;
        case (state)
            IDLE: if (accept) begin
                if (!funct3[2]) begin
                    if (MUL_STAGES == 1) begin
                        state_n = FIN;
                        load = 1'b1;
                    end else state_n = MUL;
                end else if (dz || ovf) begin
                    state_n = FIN;
                    load = 1'b1;
                    load_val = spec_res;
                end else state_n = DIV;
            end
            MUL: if (cnt == CW'(MUL_STAGES - 1)) begin
                state_n = FIN;
                load = 1'b1;
            end
            DIV: if (cnt == CW'(XLEN)) begin
                state_n = FIN;
                load = 1'b1;
                load_val = div_res;
            end
            FIN: state_n = IDLE;
        endcase
        if (flush) begin
            state_n = IDLE;
            load = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            f3 <= '0;
            a <= '0;
            b <= '0;
            rd <= '0;
            rem <= '0;
            quo <= '0;
            dv <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            result <= '0;
            rd_out <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt + 1'b1;
            if (accept) begin
                f3 <= funct3;
                a <= op_a;
                b <= op_b;
                rd <= rd_in;
                cnt <= funct3[2] ? '0 : CW'(1);
            end
            // First DIV cycle prepares magnitudes; the rest are restoring iterations
            if (state == DIV) begin
                if (cnt == '0) begin
                    neg_q <= sgn && (a[XLEN-1] ^ b[XLEN-1]);
                    neg_r <= sgn && a[XLEN-1];
                    rem <= '0;
                    quo <= (sgn && a[XLEN-1]) ? -a : a;
                    dv <= (sgn && b[XLEN-1]) ? -b : b;
                end else begin
                    rem <= rem_n;
                    quo <= quo_n;
                end
            end
            if (load) begin
                result <= load_val;
                rd_out <= state == IDLE ? rd_in : rd;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench; stimulus pushes expected result/tag/done cycle, a monitor pops on done.
module tb_muldiv_unit;
    logic clk = 1'b0, rst, start, flush, busy, done;
    logic [2:0] funct3;
    logic [31:0] op_a, op_b, result;
    logic [4:0] rd_in, rd_out;
    int cyc = 0, checks = 0, failures = 0;
    logic [31:0] last_res;
    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          cyc;
    } exp_t;
    exp_t sb[$];
    muldiv_unit #(.XLEN(32), .MUL_STAGES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .busy(busy), .done(done),
        .result(result), .rd_out(rd_out)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
        end
    endtask
    task automatic go(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                      input bit push, input logic [31:0] exp, input int lat);
        funct3 = f;
        op_a = a;
        op_b = b;
        rd_in = rd;
        start = 1'b1;
        if (push) begin
            sb.push_back('{exp, rd, cyc + lat});
            last_res = exp;
        end
        @(negedge clk);
        start = 1'b0;
    endtask
    task automatic wait_idle;
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", {31'b0, busy}, 32'd0);
    endtask
    task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] exp, input int lat);
        @(negedge clk);
        go(f, a, b, rd, 1'b1, exp, lat);
        wait_idle();
    endtask
    initial #1000000 begin
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end
    initial begin
        rst = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        funct3 = '0;
        op_a = '0;
        op_b = '0;
        rd_in = '0;
        last_res = '0;
        fork
            begin
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (!rst && done) begin
                        if (sb.size() == 0) chk("spurious_done", {31'b0, done}, 32'd0);
                        else begin
                            e = sb.pop_front();
                            chk("result", result, e.res);
                            chk("rd_out", {27'b0, rd_out}, {27'b0, e.rd});
                            chk("done_cycle", cyc, e.cyc);
                        end
                    end
                end
            end
        join_none
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_rd", {27'b0, rd_out}, 32'd0);
        run(3'b000, 32'd7, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, 2);
        run(3'b001, 32'h80000000, 32'h80000000, 5'd6, 32'h40000000, 2);
        run(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 32'hFFFFFFFE, 2);
        run(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8, 32'hFFFFFFFF, 2);
        run(3'b100, 32'hFFFFFFF9, 32'd2, 5'd9, 32'hFFFFFFFD, 34);
        run(3'b110, 32'hFFFFFFF9, 32'd2, 5'd10, 32'hFFFFFFFF, 34);
        run(3'b101, 32'd100, 32'd7, 5'd11, 32'd14, 34);
        run(3'b111, 32'd100, 32'd7, 5'd12, 32'd2, 34);
        run(3'b100, 32'd7, 32'hFFFFFFFE, 5'd13, 32'hFFFFFFFD, 34);
        run(3'b110, 32'd7, 32'hFFFFFFFE, 5'd14, 32'd1, 34);
        run(3'b111, 32'hFFFFFFFF, 32'h10, 5'd15, 32'hF, 34);
        run(3'b101, 32'd100, 32'd0, 5'd16, 32'hFFFFFFFF, 1);
        run(3'b111, 32'd100, 32'd0, 5'd17, 32'd100, 1);
        run(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'h80000000, 1);
        run(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd19, 32'd0, 1);
        run(3'b110, 32'hFFFFFFF9, 32'd0, 5'd20, 32'hFFFFFFF9, 1);
        // Flush mid-divide, then immediate restart
        @(negedge clk);
        go(3'b100, 32'd1000, 32'd3, 5'd21, 1'b0, 32'd0, 0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", {31'b0, busy}, 32'd0);
        chk("flush_result_kept", result, last_res);
        go(3'b000, 32'd3, 32'd4, 5'd22, 1'b1, 32'd12, 2);
        wait_idle();
        // start together with flush in IDLE is dropped
        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        chk("startflush_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        chk("startflush_busy2", {31'b0, busy}, 32'd0);
        // second start while busy is ignored
        @(negedge clk);
        go(3'b101, 32'd100, 32'd7, 5'd23, 1'b1, 32'd14, 34);
        repeat (4) @(negedge clk);
        funct3 = 3'b000;
        op_a = 32'd3;
        op_b = 32'd3;
        rd_in = 5'd24;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        // reset mid-divide
        @(negedge clk);
        go(3'b101, 32'd500, 32'd9, 5'd25, 1'b0, 32'd0, 0);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_done", {31'b0, done}, 32'd0);
        chk("midrst_result", result, 32'd0);
        chk("midrst_rd", {27'b0, rd_out}, 32'd0);
        rst = 1'b0;
        run(3'b000, 32'd3, 32'd4, 5'd26, 32'd12, 2);
        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
